// File: rtl/jtframe_dwnld_pkg.sv
// Shared types for the download arbiter: FSM states, byte-mask encodings, lane mapping.
package jtframe_dwnld_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WR,
      RD,
      RDW
   } state_t;

   // mask bit set = byte lane not written; bit 0 covers dout[7:0]
   localparam logic [1:0] MASK_NONE = 2'b00;
   localparam logic [1:0] MASK_HI   = 2'b10;
   localparam logic [1:0] MASK_LO   = 2'b01;

   // SWAB moves data lanes and their mask bits together
   function automatic logic [17:0] lane_map(input logic [15:0] data, input logic [1:0] mask,
                                            input bit swab);
      if (swab) lane_map = {data[7:0], data[15:8], mask[0], mask[1]};
      else      lane_map = {data, mask};
   endfunction

endpackage

// File: rtl/jtframe_dwnld_arb_if.sv
// SDRAM bank-0 request port shared by download writes and game reads.
interface jtframe_dwnld_arb_if #(
   parameter int AW = 22
);
   logic [AW-1:0] addr;
   logic [15:0]   din;
   logic [1:0]    mask;
   logic          wr;
   logic          rd;
   logic          ack;
   logic          rdy;
   logic [15:0]   dout;

   modport master (
      output addr, din, mask, wr, rd,
      input  ack, rdy, dout
   );

   modport slave (
      input  addr, din, mask, wr, rd,
      output ack, rdy, dout
   );
endinterface

// File: rtl/jtframe_dwnld_fifo.sv
// Synchronous FIFO of packed SDRAM write requests; a push while full is ignored.
module jtframe_dwnld_fifo #(
   parameter int W     = 40,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(DEPTH);

   logic [PW:0]  wr_ptr;
   logic [PW:0]  rd_ptr;
   logic [W-1:0] mem [DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign dout  = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (pop && !empty) rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push && !full) mem[wr_ptr[PW-1:0]] <= din;
   end

endmodule

// File: rtl/jtframe_dwnld_arb.sv
// Packs the ioctl byte stream into 16-bit SDRAM writes and arbitrates the bank-0
// port between queued download writes (priority) and game reads.
module jtframe_dwnld_arb
   import jtframe_dwnld_pkg::*;
#(
   parameter int            AW      = 22,
   parameter int            DEPTH   = 4,
   parameter logic [AW-1:0] ROM_END = AW'(22'h3F_FFFF),
   parameter bit            SWAB    = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          downloading,
   input  logic [24:0]   ioctl_addr,
   input  logic [7:0]    ioctl_dout,
   input  logic          ioctl_wr,
   input  logic          game_req,
   input  logic [AW-1:0] game_addr,
   output logic          game_ok,
   output logic [15:0]   game_data,
   jtframe_dwnld_arb_if.master sdram,
   output logic          dwnld_busy,
   output logic          overflow
);
   localparam int W = AW + 18;

   // packer state
   logic          pend, pend_nx;
   logic [AW-1:0] pend_addr, pend_addr_nx;
   logic [7:0]    pend_byte, pend_byte_nx;
   logic          skid_v, skid_v_nx;
   logic [AW-1:0] skid_addr, skid_addr_nx;
   logic [7:0]    skid_byte, skid_byte_nx;
   logic          dl_q, flush_due, flush_due_nx, dl_fall;

   logic          push;
   logic [AW-1:0] push_addr;
   logic [15:0]   push_data;
   logic [1:0]    push_mask;

   logic [22:0]   word;
   logic [AW-1:0] word_addr;
   logic          byte_ok;
   logic          unused_addr_msb;

   logic          fifo_full, fifo_empty, fifo_pop;
   logic [W-1:0]  fifo_in, fifo_out;
   logic [AW-1:0] head_addr;
   logic [15:0]   head_din;
   logic [1:0]    head_mask;

   // arbiter state and registered outputs
   state_t        state, state_nx;
   logic          wr_nx, rd_nx, ok_nx;
   logic [AW-1:0] addr_nx;
   logic [15:0]   din_nx, data_nx;
   logic [1:0]    mask_nx;

   assign word            = ioctl_addr[23:1];
   assign word_addr       = word[AW-1:0];
   assign unused_addr_msb = ioctl_addr[24];
   assign byte_ok         = ioctl_wr && ({9'd0, word} <= 32'(ROM_END));
   assign dl_fall         = dl_q && !downloading;

   // One push slot per cycle: skid entry first, then the new byte, then a flush
   always_comb begin
      push         = 1'b0;
      push_addr    = pend_addr;
      push_data    = {8'h00, pend_byte};
      push_mask    = MASK_HI;
      pend_nx      = pend;
      pend_addr_nx = pend_addr;
      pend_byte_nx = pend_byte;
      skid_v_nx    = 1'b0;
      skid_addr_nx = skid_addr;
      skid_byte_nx = skid_byte;
      if (skid_v) begin
         push      = 1'b1;
         push_addr = skid_addr;
         push_data = {skid_byte, 8'h00};
         push_mask = MASK_LO;
      end else if (byte_ok) begin
         if (!ioctl_addr[0]) begin
            push         = pend;
            pend_nx      = 1'b1;
            pend_addr_nx = word_addr;
            pend_byte_nx = ioctl_dout;
         end else if (pend && pend_addr == word_addr) begin
            push      = 1'b1;
            push_data = {ioctl_dout, pend_byte};
            push_mask = MASK_NONE;
            pend_nx   = 1'b0;
         end else begin
            push         = pend;
            pend_nx      = 1'b0;
            skid_v_nx    = 1'b1;
            skid_addr_nx = word_addr;
            skid_byte_nx = ioctl_dout;
         end
      end else if ((flush_due || dl_fall) && pend) begin
         push    = 1'b1;
         pend_nx = 1'b0;
      end
      flush_due_nx = (flush_due || dl_fall) && pend_nx;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend      <= 1'b0;
         pend_addr <= '0;
         pend_byte <= '0;
         skid_v    <= 1'b0;
         skid_addr <= '0;
         skid_byte <= '0;
         dl_q      <= 1'b0;
         flush_due <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         pend      <= pend_nx;
         pend_addr <= pend_addr_nx;
         pend_byte <= pend_byte_nx;
         skid_v    <= skid_v_nx;
         skid_addr <= skid_addr_nx;
         skid_byte <= skid_byte_nx;
         dl_q      <= downloading;
         flush_due <= flush_due_nx;
         if (push && fifo_full) overflow <= 1'b1;
      end
   end

   assign fifo_in = {push_addr, lane_map(push_data, push_mask, SWAB)};
   assign {head_addr, head_din, head_mask} = fifo_out;

   jtframe_dwnld_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (fifo_in),
      .pop   (fifo_pop),
      .dout  (fifo_out),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_nx = state;
      wr_nx    = sdram.wr;
      rd_nx    = sdram.rd;
      addr_nx  = sdram.addr;
      din_nx   = sdram.din;
      mask_nx  = sdram.mask;
      ok_nx    = 1'b0;
      data_nx  = game_data;
      fifo_pop = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               state_nx = WR;
               wr_nx    = 1'b1;
               addr_nx  = head_addr;
               din_nx   = head_din;
               mask_nx  = head_mask;
            end else if (game_req && !pend && !skid_v) begin
               state_nx = RD;
               rd_nx    = 1'b1;
               addr_nx  = game_addr;
            end
         end
         WR: begin
            if (sdram.ack) begin
               fifo_pop = 1'b1;
               wr_nx    = 1'b0;
               state_nx = IDLE;
            end
         end
         RD: begin
            if (sdram.ack) begin
               rd_nx    = 1'b0;
               state_nx = RDW;
            end
         end
         RDW: begin
            if (sdram.rdy) begin
               data_nx  = sdram.dout;
               ok_nx    = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         sdram.wr   <= 1'b0;
         sdram.rd   <= 1'b0;
         sdram.addr <= '0;
         sdram.din  <= '0;
         sdram.mask <= '0;
         game_ok    <= 1'b0;
         game_data  <= '0;
      end else begin
         state      <= state_nx;
         sdram.wr   <= wr_nx;
         sdram.rd   <= rd_nx;
         sdram.addr <= addr_nx;
         sdram.din  <= din_nx;
         sdram.mask <= mask_nx;
         game_ok    <= ok_nx;
         game_data  <= data_nx;
      end
   end

   assign dwnld_busy = downloading || pend || skid_v || !fifo_empty || (state == WR);

endmodule
